// File: rtl/clk_gen_multi.sv
// NUM_CLKS refclk dividers (divide/high/phase) behind an IDLE/LOAD/SETTLE/LOCKED lock FSM; no backpressure, outputs registered.
// Define CLK_GEN_MULTI_HITLESS_EN so that cfg_apply while LOCKED retunes each channel at its own wrap and keeps locked high.
module clk_gen_multi #(
   parameter int NUM_CLKS     = 2,
   parameter int DIV_W        = 16,
   parameter int LOCK_CYCLES  = 1024,
   parameter int DEFAULT_DIV  = 2,
   parameter int DEFAULT_HIGH = 1
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                en,
   input  logic                cfg_wr,
   input  logic [3:0]          cfg_sel,
   input  logic [DIV_W-1:0]    cfg_div,
   input  logic [DIV_W-1:0]    cfg_high,
   input  logic [DIV_W-1:0]    cfg_phase,
   input  logic                cfg_apply,
   output logic [NUM_CLKS-1:0] outclk,
   output logic                locked
);

   localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_CYCLES - 1);

`ifdef CLK_GEN_MULTI_HITLESS_EN
   localparam bit HITLESS = 1'b1;
`else
   localparam bit HITLESS = 1'b0;
`endif

   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic [DIV_W-1:0] high;
      logic [DIV_W-1:0] phase;
   } chan_cfg_t;

   localparam chan_cfg_t DEFAULT_CFG = {DIV_W'(DEFAULT_DIV), DIV_W'(DEFAULT_HIGH), {DIV_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, LOCKED} state_t;

   state_t           state;
   logic [SW-1:0]    settle;
   chan_cfg_t        shadow   [NUM_CLKS];
   logic [DIV_W-1:0] act_div  [NUM_CLKS];
   logic [DIV_W-1:0] act_high [NUM_CLKS];
   logic [DIV_W-1:0] cnt      [NUM_CLKS];
   logic [DIV_W-1:0] run_cnt  [NUM_CLKS];
   logic [DIV_W-1:0] ld_cnt   [NUM_CLKS];
   logic [NUM_CLKS-1:0] wrap;
`ifdef CLK_GEN_MULTI_HITLESS_EN
   logic [NUM_CLKS-1:0] pend;
`endif

   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   // Counter start so the first wrap to 0 (first rising edge) lands phase cycles late.
   function automatic logic [DIV_W-1:0] preload(input chan_cfg_t c);
      logic [DIV_W-1:0] d;
      d = eff_div(c.div);
      return (c.phase != '0 && c.phase < d) ? d - c.phase : '0;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_CLKS; i++) begin
         wrap[i]    = (cnt[i] >= eff_div(act_div[i]) - 1'b1);
         run_cnt[i] = wrap[i] ? '0 : cnt[i] + 1'b1;
         ld_cnt[i]  = preload(shadow[i]);
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CLKS; i++) shadow[i] <= DEFAULT_CFG;
      end else begin
         for (int i = 0; i < NUM_CLKS; i++) begin
            if (cfg_wr && cfg_sel == 4'(i)) shadow[i] <= {cfg_div, cfg_high, cfg_phase};
         end
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         locked <= 1'b0;
         outclk <= '0;
         settle <= '0;
         for (int i = 0; i < NUM_CLKS; i++) begin
            act_div[i]  <= DIV_W'(DEFAULT_DIV);
            act_high[i] <= DIV_W'(DEFAULT_HIGH);
            cnt[i]      <= '0;
         end
`ifdef CLK_GEN_MULTI_HITLESS_EN
         pend <= '0;
`endif
      end else if (!en) begin
         state  <= IDLE;
         locked <= 1'b0;
         outclk <= '0;
      end else begin
         case (state)
            IDLE: state <= LOAD;
            LOAD: begin
               for (int i = 0; i < NUM_CLKS; i++) begin
                  act_div[i]  <= shadow[i].div;
                  act_high[i] <= shadow[i].high;
                  cnt[i]      <= ld_cnt[i];
                  outclk[i]   <= (ld_cnt[i] < shadow[i].high);
               end
               settle <= '0;
               state  <= SETTLE;
`ifdef CLK_GEN_MULTI_HITLESS_EN
               pend <= '0;
`endif
            end
            SETTLE, LOCKED: begin
               if (cfg_apply && !(HITLESS && state == LOCKED)) begin
                  state  <= LOAD;
                  locked <= 1'b0;
                  outclk <= '0;
               end else begin
                  for (int i = 0; i < NUM_CLKS; i++) begin
`ifdef CLK_GEN_MULTI_HITLESS_EN
                     // Retune exactly at the wrap so the old period completes cleanly.
                     if (pend[i] && wrap[i]) begin
                        act_div[i]  <= shadow[i].div;
                        act_high[i] <= shadow[i].high;
                        cnt[i]      <= '0;
                        outclk[i]   <= (shadow[i].high != '0);
                        pend[i]     <= 1'b0;
                     end else
`endif
                     begin
                        cnt[i]    <= run_cnt[i];
                        outclk[i] <= (run_cnt[i] < act_high[i]);
                     end
                  end
`ifdef CLK_GEN_MULTI_HITLESS_EN
                  if (cfg_apply && state == LOCKED) pend <= '1;
`endif
                  if (state == SETTLE) begin
                     if (settle == SETTLE_LAST) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end else begin
                        settle <= settle + 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi: stimulus queues expected {outclk, locked}, a negedge monitor pops and compares.
module tb_clk_gen_multi;

   logic        refclk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [3:0]  cfg_sel = 4'd0;
   logic [15:0] cfg_div = 16'd0;
   logic [15:0] cfg_high = 16'd0;
   logic [15:0] cfg_phase = 16'd0;
   logic        cfg_apply = 1'b0;
   logic [1:0]  outclk;
   logic        locked;

   logic [2:0]  exp_q [$];
   string       name_q [$];
   logic [2:0]  mon_exp;
   string       mon_nm;
   int          n_cmp = 0;
   int          n_bad = 0;

   clk_gen_multi #(
      .NUM_CLKS(2), .DIV_W(16), .LOCK_CYCLES(8), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)
   ) dut (
      .refclk(refclk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
      .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
      .cfg_apply(cfg_apply), .outclk(outclk), .locked(locked)
   );

   always #5 refclk = ~refclk;

   // One clock: inputs set beforehand are sampled at the posedge; expectation for that edge is queued.
   task automatic tick(input logic [1:0] oc, input logic lk, input logic chk, input string nm);
      @(posedge refclk);
      if (chk) begin
         exp_q.push_back({oc, lk});
         name_q.push_back(nm);
      end
      @(negedge refclk);
      cfg_wr    = 1'b0;
      cfg_apply = 1'b0;
   endtask

   task automatic set_wr(input logic [3:0] s, input logic [15:0] d, input logic [15:0] h, input logic [15:0] p);
      cfg_wr    = 1'b1;
      cfg_sel   = s;
      cfg_div   = d;
      cfg_high  = h;
      cfg_phase = p;
   endtask

   initial begin
      forever begin
         @(negedge refclk);
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            n_cmp++;
            if ({outclk, locked} !== mon_exp) begin
               n_bad++;
               $display("FAIL %s: got outclk=%b locked=%b, want outclk=%b locked=%b",
                        mon_nm, outclk, locked, mon_exp[2:1], mon_exp[0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge refclk);
      tick(2'b00, 1'b0, 1'b1, "reset");
      tick(2'b00, 1'b0, 1'b1, "reset_hold");
      rst = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "idle_no_en");
      en = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "load");
      for (int k = 1; k <= 12; k++) tick({2{k % 2 == 1}}, k >= 9, 1'b1, "dflt_run");

`ifdef CLK_GEN_MULTI_HITLESS_EN
      set_wr(4'd0, 16'd6, 16'd3, 16'd0);
      tick(2'b11, 1'b1, 1'b1, "shadow_only");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b1, 1'b1, "hitless_apply");
      for (int k = 1; k <= 14; k++) tick({k % 2 == 1, ((k - 1) % 6) < 3}, 1'b1, 1'b1, "hitless_switch");
`else
      set_wr(4'd1, 16'd10, 16'd5, 16'd3);
      tick(2'b11, 1'b1, 1'b1, "shadow_only");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_drop");
      for (int k = 1; k <= 20; k++) tick({((k + 6) % 10) < 5, k % 2 == 1}, k >= 9, 1'b1, "ch1_div10_ph3");

      set_wr(4'd0, 16'd0, 16'd1, 16'd0);
      tick(2'b00, 1'b0, 1'b0, "");
      set_wr(4'd1, 16'd4, 16'd0, 16'd0);
      tick(2'b00, 1'b0, 1'b0, "");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_bnd");
      for (int k = 1; k <= 12; k++) tick(2'b01, k >= 9, 1'b1, "bnd_div0_high0");

      set_wr(4'd1, 16'd4, 16'd7, 16'd0);
      tick(2'b00, 1'b0, 1'b0, "");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_bnd2");
      for (int k = 1; k <= 10; k++) tick(2'b11, k >= 9, 1'b1, "bnd_high_ge_div");

      set_wr(4'd5, 16'd3, 16'd2, 16'd1);
      tick(2'b00, 1'b0, 1'b0, "");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_bad_sel");
      for (int k = 1; k <= 10; k++) tick(2'b11, k >= 9, 1'b1, "bad_sel_keep");

      set_wr(4'd0, 16'd4, 16'd2, 16'd1);
      tick(2'b00, 1'b0, 1'b0, "");
      set_wr(4'd1, 16'd2, 16'd1, 16'd0);
      tick(2'b00, 1'b0, 1'b0, "");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_mix");
      for (int k = 1; k <= 4; k++) tick({k % 2 == 1, ((k + 2) % 4) < 2}, 1'b0, 1'b1, "settle_run");
      en = 1'b0;
      tick(2'b00, 1'b0, 1'b1, "en_off");
      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_idle");
      en = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "reload");
      for (int k = 1; k <= 10; k++) tick({k % 2 == 1, ((k + 2) % 4) < 2}, k >= 9, 1'b1, "reenable");

      // Reset pulse lies wholly between two clock edges: only an async reset clears outputs here.
      @(posedge refclk);
      #1 rst = 1'b0;
      exp_q.push_back(3'b000);
      name_q.push_back("rst_async");
      @(negedge refclk);
      #1 rst = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "post_rst_load");
      for (int k = 1; k <= 10; k++) tick({2{k % 2 == 1}}, k >= 9, 1'b1, "post_rst_dflt");

      cfg_apply = 1'b1;
      tick(2'b00, 1'b0, 1'b1, "apply_hold");
      cfg_apply = 1'b1;
      tick(2'b11, 1'b0, 1'b1, "apply_in_load");
      for (int k = 2; k <= 10; k++) tick({2{k % 2 == 1}}, k >= 9, 1'b1, "after_hold");
`endif

      @(negedge refclk);
      @(negedge refclk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Parametrised digital clock-generation block with NUM_CLKS independent divided outputs derived from refclk.
- Each channel has a runtime-programmable divide ratio, high time (duty) and phase offset.
- A lock/settle state machine drives a "locked" status, so downstream logic can gate on it the same way it gates on a PLL lock.
- Sits beside the board PLL. Generates the low-rate enables/clocks (e.g. 10 MHz, 1 MHz ticks) from the PLL output.

Parameters:
- NUM_CLKS, 2, number of output channels (1..16).
- DIV_W, 16, width of divide, high-time and phase fields.
- LOCK_CYCLES, 1024, refclk cycles spent in SETTLE before locked asserts (>=1).
- DEFAULT_DIV, 2, divide ratio loaded into every channel's shadow at reset.
- DEFAULT_HIGH, 1, high time loaded into every channel's shadow at reset.

Ports:
- refclk  input  1  sole clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global enable; low forces IDLE.
- cfg_wr  input  1  single-cycle write strobe for one channel's shadow config.
- cfg_sel  input  4  channel index for cfg_wr.
- cfg_div  input  DIV_W  divide ratio; 0 is treated as 1.
- cfg_high  input  DIV_W  high time in refclk cycles.
- cfg_phase  input  DIV_W  phase offset in refclk cycles.
- cfg_apply  input  1  pulse: transfer all shadows to active config.
- outclk  output  NUM_CLKS  registered divided outputs.
- locked  output  1  high when all channels are running the current active config and settled.

Behaviour:
- Reset (rst low, async):
  - State = IDLE; outclk = 0; locked = 0; settle counter = 0.
  - Every shadow loads div = DEFAULT_DIV, high = DEFAULT_HIGH, phase = 0.
  - Active config is loaded with the same values.
- cfg_wr:
  - Captures cfg_div, cfg_high and cfg_phase into the shadow of channel cfg_sel on the same edge.
  - If cfg_sel >= NUM_CLKS, the write is ignored.
  - Shadow writes never affect outclk until the config is applied.
- State machine IDLE -> LOAD -> SETTLE -> LOCKED:
  - IDLE: outclk = 0, locked = 0, counters held. If en = 1, go to LOAD next edge.
  - LOAD (exactly 1 cycle): active config := shadow for all channels. Channel counter cnt preloads to (div - phase) if phase < div, else 0; phase >= div is treated as 0. outclk = 0. Settle counter cleared. Go to SETTLE.
  - SETTLE: channels run. Settle counter increments each cycle. When it reaches LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: locked = 1, registered, so it first reads high LOCK_CYCLES+1 cycles after LOAD.
  - cfg_apply in SETTLE or LOCKED goes to LOAD next edge and locked drops in that same edge (subject to the optional feature). cfg_apply in IDLE is ignored; shadows are still loaded on the next en.
  - en = 0 in any state goes to IDLE next edge: outclk = 0, locked = 0.
- Channel counter:
  - cnt runs 0..div-1 and wraps to 0.
  - outclk[i] is registered and equals (cnt_next < high). high = 0 gives constant 0; high >= div gives constant 1.
  - div = 1 with 0 < high gives constant 1.
  - Period = div refclk cycles exactly. With phase p, the first rising edge is p+1 cycles after the LOAD cycle; with p = 0 it is 1 cycle after LOAD.
- Simultaneous events:
  - cfg_wr and cfg_apply in the same cycle: the write lands in the shadow, and the following LOAD uses it.
  - cfg_apply during LOAD is ignored.
  - rst assertion mid-operation forces reset values immediately and asynchronously.

Optional Feature:
- Macro: CLK_GEN_MULTI_HITLESS_EN.
- Defined:
  - cfg_apply while LOCKED does not enter LOAD and locked stays 1.
  - Each channel adopts its shadow config on its own wrap, i.e. the cycle cnt = div-1; cnt then continues from 0 and phase is ignored.
  - A channel whose shadow equals its active config is unaffected.
  - cfg_apply in SETTLE behaves as in the non-hitless case.
- Undefined: cfg_apply while LOCKED goes through LOAD and SETTLE as above.

Test Plan:
- Reset, en=1, defaults (div=2, high=1, NUM_CLKS=2, LOCK_CYCLES=8) -> both outclk toggle with period 2 and rise 1 cycle after LOAD; locked rises 9 cycles after LOAD.
- Write ch1 div=10, high=5, phase=3, then cfg_apply -> locked drops next edge; ch1 has period 10, 5 high, first rise 4 cycles after LOAD; ch0 unchanged, period 2, restarted.
- Boundary config: ch0 div=0/high=1, ch1 div=4/high=0, then div=4/high=7 -> constant 1; constant 0; constant 1.
- cfg_sel=5 write with NUM_CLKS=2, then apply -> both channels keep prior config.
- en deasserted mid-SETTLE, then rst pulsed mid-LOCKED -> outclk=0 and locked=0 next edge, then immediately on rst; re-enable runs a full LOAD/SETTLE.
- With CLK_GEN_MULTI_HITLESS_EN, apply ch0 div=2 -> div=6 while LOCKED -> locked stays 1; ch0 switches exactly at its next wrap with no runt pulse.
